pc_counter_16: RTL and testbench
================================

# pc_counter_16

16-bit program counter register for the datapath lab CPU. It holds the current instruction address and drives the 16-bit ripple incrementer. On each enabled clock it captures either the incrementer's +1 result, a jump target, or a saved return address. It is the stateful stage wrapped around the incrementer.

## Interface
- `WIDTH`, default 16: address width. Only 16 is supported.
- `RESET_VEC`, default 16'h0000: value loaded into `pc` on reset.

- `clk`, input, 1: single system clock. All state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `en`, input, 1: advance enable. When 0, all state holds (stall).
- `load`, input, 1: jump request. `pc <= load_addr`.
- `call`, input, 1: call request. Jumps to `load_addr` and saves the return address.
- `ret`, input, 1: return request. `pc <= link`.
- `load_addr`, input, 16: jump or call target.
- `pc`, output, 16: current address, registered.
- `pc_plus1`, output, 16: combinational incrementer output, `pc + 1` mod 2^16.
- `link`, output, 16: saved return address, registered.
- `wrap`, output, 1: sticky flag, set when an increment wraps from 16'hFFFF to 16'h0000.

## Operation
- The action is chosen once per rising edge with `en` = 1, in strict priority order:
  1. `load`: `pc <= load_addr`; `wrap <= 0`.
  2. `call`: `pc <= load_addr`; `link <= pc_plus1`; `wrap <= 0`.
  3. `ret`: `pc <= link`; `wrap <= 0`; `link` is unchanged.
  4. Otherwise increment: `pc <= pc_plus1`. If `pc` == 16'hFFFF, `wrap <= 1`.
- A lower-priority request asserted in the same cycle as a higher one is dropped, with no side effects. For example, `load` together with `call` does not update `link`.
- `en` = 0: `pc`, `link` and `wrap` all hold, regardless of `load`/`call`/`ret`.
- Arithmetic:
  - All arithmetic is modulo 2^16. The carry out of the incrementer is not a port.
  - `wrap` is the only trace of overflow. It stays at 1 until reset or until a load, call or return.
- `pc_plus1` is always `pc + 1`. It does not depend on the request inputs.

## Timing
- Latency: a request sampled at edge N is visible on `pc` and `link` immediately after edge N. The block has no pipelining.
- `pc_plus1` settles combinationally from `pc` within the same cycle.
- Reset values, applied asynchronously and independent of `clk`:
  - `pc` = `RESET_VEC`
  - `link` = 16'h0000
  - `wrap` = 0
- Reset asserted mid-cycle overrides any pending request.
- First action after `rst` deasserts: the first rising edge with `en` = 1.
- A `ret` immediately after a `call` (consecutive enabled edges) returns to the call site + 1.

## Configuration
- Macro: `PC_LINK_EN`.
- Defined: `call`, `ret` and the `link` register behave as described above.
- Not defined:
  - The `link` register is not built and `link` is tied to 16'h0000.
  - `call` behaves exactly like `load`.
  - `ret` is ignored, so the cycle falls through to increment, or to hold when `en` = 0.
  - The port list is unchanged, so integration is the same for both builds.

## Structure
- Shared package holds:
  - the address width constant (16);
  - the reset vector constant;
  - an enumerated action type (LOAD, CALL, RET, INC, HOLD) used by the priority decode.
- One natural sub-module: `pc_incrementer`, a 16-bit +1 chain of half adders built from NAND primitives. It has input `pc` and output `pc_plus1`.
- The top level contains only the priority decode, the `pc`/`link`/`wrap` registers and the `PC_LINK_EN` guards.

## Test plan
- Reset with `RESET_VEC` = 16'h0100: assert `rst` asynchronously between edges. Expect `pc` = 16'h0100, `link` = 0, `wrap` = 0 before the next edge. Release, then 3 enabled edges: expect `pc` = 16'h0103.
- Wrap: load 16'hFFFE, then 2 increments. Expect `pc` = 16'hFFFF, then 16'h0000 with `wrap` = 1. Further increments keep `wrap` = 1. A load of 16'h0010 clears `wrap`.
- Call and return (with `PC_LINK_EN`): `pc` = 16'h0042, `call` with `load_addr` = 16'h2000. Expect `pc` = 16'h2000, `link` = 16'h0043. Two increments, then `ret`: expect `pc` = 16'h0043.
- Priority: `load` + `call` + `ret` together with `load_addr` = 16'h1234. Expect `pc` = 16'h1234 and `link` unchanged. Then `call` + `ret` together: expect a call (`link` updated).
- Stall: `en` = 0 for 4 edges while toggling `load`/`call`/`ret`. Expect `pc`, `link` and `wrap` all unchanged. `pc_plus1` always equals `pc` + 1.
- Without `PC_LINK_EN`:
  - `call` to 16'h2000 gives `pc` = 16'h2000 and `link` = 0.
  - `ret` alone from `pc` = 16'h2000 gives `pc` = 16'h2001.

Source files
------------

// File: rtl/pc_counter_16_pkg.sv
// pc_counter_16_pkg: shared width, reset vector and action encoding for the program counter
package pc_counter_16_pkg;
    localparam int PC_WIDTH = 16;
    localparam logic [PC_WIDTH-1:0] PC_RESET_VEC = 16'h0000;
    typedef enum logic [2:0] {
        ACT_LOAD,
        ACT_CALL,
        ACT_RET,
        ACT_INC,
        ACT_HOLD
    } pc_action_e;
endpackage

// File: rtl/pc_counter_16_incrementer.sv
// pc_incrementer: +1 ripple chain of NAND-built half adders, modulo 2^WIDTH
module pc_incrementer
    import pc_counter_16_pkg::*;
#(
    parameter int WIDTH = PC_WIDTH
) (
    input  logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus1
);
    logic [WIDTH-1:0] c;
    assign c[0] = 1'b1;
    for (genvar i = 0; i < WIDTH; i++) begin : g_ha
        logic n1, n2, n3;
        nand u_n1 (n1, pc[i], c[i]);
        nand u_n2 (n2, pc[i], n1);
        nand u_n3 (n3, c[i], n1);
        nand u_s  (pc_plus1[i], n2, n3);
        // the final carry is the dropped overflow, so it is never built
        if (i < WIDTH - 1) begin : g_c
            nand u_c (c[i+1], n1, n1);
        end
    end
endmodule

// File: rtl/pc_counter_16.sv
// pc_counter_16: program counter with load/call/ret priority and sticky wrap; PC_LINK_EN builds the link register
module pc_counter_16
    import pc_counter_16_pkg::*;
#(
    parameter int WIDTH = PC_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VEC = PC_RESET_VEC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic             call,
    input  logic             ret,
    input  logic [WIDTH-1:0] load_addr,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus1,
    output logic [WIDTH-1:0] link,
    output logic             wrap
);
    pc_action_e act;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic wrap_q, wrap_d;

    pc_incrementer #(.WIDTH(WIDTH)) u_inc (
        .pc       (pc_q),
        .pc_plus1 (pc_plus1)
    );

`ifdef PC_LINK_EN
    logic [WIDTH-1:0] link_q, link_d;
    always_comb begin
        act = !en ? ACT_HOLD : load ? ACT_LOAD : call ? ACT_CALL : ret ? ACT_RET : ACT_INC;
        link_d = (act == ACT_CALL) ? pc_plus1 : link_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) link_q <= '0;
        else link_q <= link_d;
    end
    assign link = link_q;
`else
    logic unused_ret;
    assign unused_ret = ret;
    // call degrades to a plain jump when no return address is kept
    always_comb act = !en ? ACT_HOLD : (load || call) ? ACT_LOAD : ACT_INC;
    assign link = '0;
`endif

    always_comb begin
        pc_d = (act == ACT_LOAD || act == ACT_CALL) ? load_addr :
               (act == ACT_RET) ? link :
               (act == ACT_INC) ? pc_plus1 : pc_q;
        wrap_d = (act == ACT_HOLD) ? wrap_q :
                 (act == ACT_INC) ? (wrap_q | (pc_q == {WIDTH{1'b1}})) : 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q   <= RESET_VEC;
            wrap_q <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            wrap_q <= wrap_d;
        end
    end

    assign pc   = pc_q;
    assign wrap = wrap_q;
endmodule

// File: tb/tb_pc_counter_16.sv
// tb_pc_counter_16: directed vectors against a behavioural program-counter model, checked every cycle
module tb_pc_counter_16;
`ifdef PC_LINK_EN
    localparam bit LINK = 1'b1;
`else
    localparam bit LINK = 1'b0;
`endif
    logic clk = 1'b0, rst = 1'b0, en = 1'b0, load = 1'b0, call = 1'b0, ret = 1'b0;
    logic [15:0] load_addr = '0;
    logic [15:0] pc, pc_plus1, link;
    logic wrap;
    logic [15:0] m_pc, m_lk;
    logic m_w;
    bit run = 1'b0;
    int total = 0, bad = 0;

    pc_counter_16 #(.WIDTH(16), .RESET_VEC(16'h0100)) dut (
        .clk(clk), .rst(rst), .en(en), .load(load), .call(call), .ret(ret),
        .load_addr(load_addr), .pc(pc), .pc_plus1(pc_plus1), .link(link), .wrap(wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) if (run) begin
        check("pc", pc, m_pc);
        check("pc_plus1", pc_plus1, m_pc + 16'd1);
        check("link", link, m_lk);
        check("wrap", {15'd0, wrap}, {15'd0, m_w});
    end

    task automatic step(input logic e, l, c, r, input logic [15:0] a);
        en = e; load = l; call = c; ret = r; load_addr = a;
        @(posedge clk);
        if (e) begin
            if (l || (c && !LINK)) begin
                m_pc = a; m_w = 1'b0;
            end else if (c) begin
                m_lk = m_pc + 16'd1; m_pc = a; m_w = 1'b0;
            end else if (r && LINK) begin
                m_pc = m_lk; m_w = 1'b0;
            end else begin
                if (m_pc == 16'hFFFF) m_w = 1'b1;
                m_pc = m_pc + 16'd1;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        #2 rst = 1'b1;
        m_pc = 16'h0100; m_lk = 16'h0000; m_w = 1'b0;
        #1;
        check({tag, "_pc"}, pc, 16'h0100);
        check({tag, "_link"}, link, 16'h0000);
        check({tag, "_wrap"}, {15'd0, wrap}, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        do_reset("reset");
        run = 1'b1;
        repeat (3) step(1, 0, 0, 0, 16'h0);
        check("after_3_inc", pc, 16'h0103);

        step(1, 1, 0, 0, 16'hFFFE);
        step(1, 0, 0, 0, 16'h0);
        check("pc_ffff", pc, 16'hFFFF);
        check("no_wrap_yet", {15'd0, wrap}, 16'h0000);
        step(1, 0, 0, 0, 16'h0);
        check("pc_wrapped", pc, 16'h0000);
        check("wrap_set", {15'd0, wrap}, 16'h0001);
        step(1, 0, 0, 0, 16'h0);
        check("wrap_sticky", {15'd0, wrap}, 16'h0001);
        step(1, 1, 0, 0, 16'h0010);
        check("load_clear_pc", pc, 16'h0010);
        check("load_clear_wrap", {15'd0, wrap}, 16'h0000);

        step(1, 1, 0, 0, 16'h0042);
        step(1, 0, 1, 0, 16'h2000);
        check("call_pc", pc, 16'h2000);
        check("call_link", link, LINK ? 16'h0043 : 16'h0000);
        step(1, 0, 0, 0, 16'h0);
        step(1, 0, 0, 0, 16'h0);
        step(1, 0, 0, 1, 16'h0);
        check("ret_pc", pc, LINK ? 16'h0043 : 16'h2003);

        step(1, 1, 1, 1, 16'h1234);
        check("prio_load_pc", pc, 16'h1234);
        check("prio_load_link", link, LINK ? 16'h0043 : 16'h0000);
        step(1, 0, 1, 1, 16'h3000);
        check("prio_call_pc", pc, 16'h3000);
        check("prio_call_link", link, LINK ? 16'h1235 : 16'h0000);

        step(1, 1, 0, 0, 16'hFFFF);
        step(1, 0, 0, 0, 16'h0);
        step(0, 1, 0, 0, 16'hAAAA);
        step(0, 0, 1, 0, 16'h5555);
        step(0, 0, 0, 1, 16'h1111);
        step(0, 1, 1, 1, 16'h2222);
        check("stall_pc", pc, 16'h0000);
        check("stall_wrap", {15'd0, wrap}, 16'h0001);
        check("stall_link", link, LINK ? 16'h1235 : 16'h0000);

        step(1, 0, 1, 0, 16'h2000);
        check("call2_pc", pc, 16'h2000);
        check("call2_wrap", {15'd0, wrap}, 16'h0000);
        step(1, 0, 0, 1, 16'h0);
        check("ret_after_call", pc, LINK ? 16'h0001 : 16'h2001);

        step(1, 0, 0, 0, 16'h0);
        do_reset("midreset");
        step(1, 0, 0, 0, 16'h0);
        check("post_reset_inc", pc, 16'h0101);

        run = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
